// File: rtl/i2c_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_xfer_sequencer
//
// Drives an OpenCores-style I2C master core through its 8-bit register port
// to perform single-byte writes and reads on behalf of a simple
// valid/ready request interface. After reset the prescaler is programmed and
// the core is enabled. The block then waits for requests.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_rw                 0 = write one byte, 1 = read one byte
//   req_addr, req_wdata    7-bit slave address, write byte
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata, rsp_status  read byte; 00 OK, 01 NACK, 10 arb lost, 11 timeout
//   reg_adr/reg_dat_o/reg_we/reg_stb  register access request toward the core
//   reg_dat_i/reg_ack      register read data and access completion
//
// State        | Meaning
// -------------+------------------------------------------------------------
// INIT_LO      | write PRERlo = PRESCALE[7:0]
// INIT_HI      | write PRERhi = PRESCALE[15:8]
// INIT_EN      | write CTR = 0x80 (core enable)
// IDLE         | req_ready high, wait for a request
// TX_ADDR      | write TXR = {addr, rw}
// CR_START     | write CR = STA|WR
// POLL         | read SR until TIP clears (AL / timeout abort)
// TX_DATA      | write TXR = write byte
// CR_WRSTOP    | write CR = STO|WR
// CR_RDSTOP    | write CR = RD|ACK|STO
// RD_RXR       | read RXR into rsp_rdata
// CR_STOP      | write CR = STO (after address NACK or timeout)
// POLL_BUSY    | read SR until BUSY clears
// RESP         | rsp_valid pulse
// ---------------------------------------------------------------------------
module i2c_xfer_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'h0063,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic [2:0] reg_adr,
    output logic [7:0] reg_dat_o,
    input  logic [7:0] reg_dat_i,
    output logic       reg_we,
    output logic       reg_stb,
    input  logic       reg_ack
);

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;

    localparam logic [7:0] CTR_EN     = 8'h80;
    localparam logic [7:0] CR_STA_WR  = 8'h90;
    localparam logic [7:0] CR_STO_WR  = 8'h50;
    localparam logic [7:0] CR_RD_STO  = 8'h68;
    localparam logic [7:0] CR_STO     = 8'h40;

    localparam int SR_TIP   = 1;
    localparam int SR_AL    = 5;
    localparam int SR_BUSY  = 6;
    localparam int SR_RXACK = 7;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_ARB  = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        INIT_LO, INIT_HI, INIT_EN, IDLE, TX_ADDR, CR_START, POLL,
        TX_DATA, CR_WRSTOP, CR_RDSTOP, RD_RXR, CR_STOP, POLL_BUSY, RESP
    } state_t;

    // Which command the shared POLL state is waiting on.
    typedef enum logic [1:0] {PH_ADDR, PH_WR, PH_RD} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [2:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;

    // Access wanted by the current state.
    logic        acc_en;
    logic        acc_we;
    logic [2:0]  acc_adr;
    logic [7:0]  acc_dat;
    logic        acc_done;
    logic        poll_last;

    always_comb begin
        acc_en  = 1'b1;
        acc_we  = 1'b1;
        acc_adr = ADR_CR;
        acc_dat = 8'h00;
        case (state_q)
            INIT_LO: begin
                acc_adr = ADR_PRERLO;
                acc_dat = PRESCALE[7:0];
            end
            INIT_HI: begin
                acc_adr = ADR_PRERHI;
                acc_dat = PRESCALE[15:8];
            end
            INIT_EN: begin
                acc_adr = ADR_CTR;
                acc_dat = CTR_EN;
            end
            TX_ADDR: begin
                acc_adr = ADR_TXR;
                acc_dat = {addr_q, rw_q};
            end
            CR_START:  acc_dat = CR_STA_WR;
            TX_DATA: begin
                acc_adr = ADR_TXR;
                acc_dat = wdata_q;
            end
            CR_WRSTOP: acc_dat = CR_STO_WR;
            CR_RDSTOP: acc_dat = CR_RD_STO;
            CR_STOP:   acc_dat = CR_STO;
            POLL, POLL_BUSY: acc_we = 1'b0;
            RD_RXR: begin
                acc_we  = 1'b0;
                acc_adr = ADR_TXR;
            end
            default:   acc_en = 1'b0;
        endcase
    end

    // Single outstanding access: raise stb with stable fields, drop it the
    // cycle after ack. A state that needs another access re-raises stb on
    // the following cycle, so consecutive accesses are separated by one idle.
    always_comb begin
        acc_done = 1'b0;
        stb_d    = stb_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        if (acc_en) begin
            if (!stb_q) begin
                stb_d = 1'b1;
                we_d  = acc_we;
                adr_d = acc_adr;
                dat_d = acc_dat;
            end else if (reg_ack) begin
                stb_d    = 1'b0;
                acc_done = 1'b1;
            end
        end
    end

    assign poll_last = (poll_cnt_q == POLL_LAST);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        poll_cnt_d = poll_cnt_q;

        // Counter is zero whenever a poll state is entered.
        if (state_q != POLL && state_q != POLL_BUSY) begin
            poll_cnt_d = '0;
        end

        case (state_q)
            INIT_LO:  if (acc_done) state_d = INIT_HI;
            INIT_HI:  if (acc_done) state_d = INIT_EN;
            INIT_EN:  if (acc_done) state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    rw_d     = req_rw;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    status_d = ST_OK;
                    phase_d  = PH_ADDR;
                    state_d  = TX_ADDR;
                end
            end
            TX_ADDR:  if (acc_done) state_d = CR_START;
            CR_START: if (acc_done) state_d = POLL;
            POLL: begin
                if (acc_done) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    if (reg_dat_i[SR_AL]) begin
                        // Bus is no longer ours: no STOP may be issued.
                        status_d = ST_ARB;
                        state_d  = RESP;
                    end else if (!reg_dat_i[SR_TIP]) begin
                        case (phase_q)
                            PH_ADDR: begin
                                if (reg_dat_i[SR_RXACK]) begin
                                    status_d = ST_NACK;
                                    state_d  = CR_STOP;
                                end else if (rw_q) begin
                                    state_d = CR_RDSTOP;
                                end else begin
                                    state_d = TX_DATA;
                                end
                            end
                            PH_WR: begin
                                status_d = reg_dat_i[SR_RXACK] ? ST_NACK : ST_OK;
                                state_d  = RESP;
                            end
                            default: state_d = RD_RXR;
                        endcase
                    end else if (poll_last) begin
                        status_d = ST_TMO;
                        state_d  = CR_STOP;
                    end
                end
            end
            TX_DATA:  if (acc_done) state_d = CR_WRSTOP;
            CR_WRSTOP: begin
                if (acc_done) begin
                    phase_d = PH_WR;
                    state_d = POLL;
                end
            end
            CR_RDSTOP: begin
                if (acc_done) begin
                    phase_d = PH_RD;
                    state_d = POLL;
                end
            end
            RD_RXR: begin
                if (acc_done) begin
                    rdata_d = reg_dat_i;
                    state_d = RESP;
                end
            end
            CR_STOP: begin
                // A timed-out transfer skips the BUSY wait; it would likely
                // hang on the same stuck core.
                if (acc_done) begin
                    state_d = (status_q == ST_TMO) ? RESP : POLL_BUSY;
                end
            end
            POLL_BUSY: begin
                if (acc_done) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    if (!reg_dat_i[SR_BUSY]) begin
                        state_d = RESP;
                    end else if (poll_last) begin
                        status_d = ST_TMO;
                        state_d  = CR_STOP;
                    end
                end
            end
            RESP:     state_d = IDLE;
            default:  state_d = INIT_LO;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= INIT_LO;
            phase_q    <= PH_ADDR;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            rdata_q    <= '0;
            status_q   <= ST_OK;
            poll_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            poll_cnt_q <= poll_cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;
    assign reg_stb    = stb_q;
    assign reg_we     = we_q;
    assign reg_adr    = adr_q;
    assign reg_dat_o  = dat_q;

endmodule
